// File: rtl/draw_command_queue_if.sv
// Bundle of the producer-side command push signals, the queue status flags and
// the draw request/command fields exchanged with the square-draw stage.
// slave  : the queue's view (receives pushes and ready, drives status and draw).
// master : the surrounding system's view (producer plus downstream stage).
interface draw_command_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // producer side
  logic          push;
  logic [7:0]    pushX;
  logic [8:0]    pushY;
  logic [7:0]    pushWidth;
  logic [8:0]    pushHeight;
  logic [15:0]   pushColour;

  // status
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  // downstream side
  logic          draw;
  logic [7:0]    xOrigin;
  logic [8:0]    yOrigin;
  logic [7:0]    width;
  logic [8:0]    height;
  logic [15:0]   pixelData;
  logic          ready;

  modport slave (
    input  push, pushX, pushY, pushWidth, pushHeight, pushColour, ready,
    output full, empty, count, overflow,
           draw, xOrigin, yOrigin, width, height, pixelData
  );

  modport master (
    output push, pushX, pushY, pushWidth, pushHeight, pushColour, ready,
    input  full, empty, count, overflow,
           draw, xOrigin, yOrigin, width, height, pixelData
  );
endinterface

// File: rtl/draw_command_queue.sv
// Rectangle draw command queue feeding the square-draw stage of the LT24 display.
// Producers push a full command in one cycle; the queue issues one command at a
// time with draw and holds the fields stable until the downstream acknowledges
// by dropping ready (or the acknowledge timer expires).
// Optional feature: define DRAW_QUEUE_CLIP_EN to clip pushed rectangles to the
// 240x320 display and discard rectangles whose origin lies off-screen.
module draw_command_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset_n,
  draw_command_queue_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int unsigned EW = 50;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK,
    BUSY
  } state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          draw_q;
  logic [TW-1:0] timer;

  logic [7:0]    x_q;
  logic [8:0]    y_q;
  logic [7:0]    w_q;
  logic [8:0]    h_q;
  logic [15:0]   c_q;

  logic [7:0]    w_eff;
  logic [8:0]    h_eff;
  logic          in_range;
  logic          push_ok;
  logic          pop;
  logic [EW-1:0] head;

`ifdef DRAW_QUEUE_CLIP_EN
  logic [8:0]    sum_x;
  logic [9:0]    sum_y;
`endif

  // Effective size after optional clipping, and whether the origin is usable
  always_comb begin
    w_eff    = bus.pushWidth;
    h_eff    = bus.pushHeight;
    in_range = 1'b1;
`ifdef DRAW_QUEUE_CLIP_EN
    sum_x    = {1'b0, bus.pushX} + {1'b0, bus.pushWidth};
    sum_y    = {1'b0, bus.pushY} + {1'b0, bus.pushHeight};
    if (sum_x > 9'd240) begin
      w_eff = 8'(9'd240 - {1'b0, bus.pushX});
    end
    if (sum_y > 10'd320) begin
      h_eff = 9'(10'd320 - {1'b0, bus.pushY});
    end
    in_range = (bus.pushX < 8'd240) && (bus.pushY < 9'd320);
`endif
  end

  // Push acceptance, pop on leaving IDLE, and the resulting occupancy
  always_comb begin
    push_ok   = bus.push && !full_q && in_range &&
                (w_eff != '0) && (h_eff != '0);
    pop       = (state == IDLE) && !empty_q && bus.ready;
    count_nxt = count_q;
    if (push_ok && !pop) begin
      count_nxt = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_nxt = count_q - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

  // Entry storage; contents are only meaningful between write and read pointers
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= {bus.pushX, bus.pushY, w_eff, h_eff, bus.pushColour};
    end
  end

  // Pointers, occupancy, registered flags and sticky overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.push && full_q) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // Issue FSM with registered draw and command field outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      draw_q <= 1'b0;
      timer  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      w_q    <= '0;
      h_q    <= '0;
      c_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          draw_q <= 1'b0;
          if (!empty_q && bus.ready) begin
            {x_q, y_q, w_q, h_q, c_q} <= head;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          draw_q <= 1'b1;
          timer  <= '0;
          state  <= ACK;
        end
        ACK: begin
          if (!bus.ready) begin
            draw_q <= 1'b0;
            state  <= BUSY;
          end else if (timer == TW'(ACK_TIMEOUT)) begin
            draw_q <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BUSY: begin
          draw_q <= 1'b0;
          if (bus.ready) begin
            state <= IDLE;
          end
        end
        default: begin
          draw_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.draw      = draw_q;
  assign bus.xOrigin   = x_q;
  assign bus.yOrigin   = y_q;
  assign bus.width     = w_q;
  assign bus.height    = h_q;
  assign bus.pixelData = c_q;

endmodule
